// File: rtl/ysyx_23060077_id_ctrl.sv
// ID-stage sequencer: one-entry stage register, valid/ready on both sides, per-register in-flight write scoreboard.
// Optional YSYX_23060077_WB_BYPASS_EN lets a same-cycle retire release a source whose counter is 1.
module ysyx_23060077_id_ctrl #(
  parameter int REG_WIDTH = 4,
  parameter int CNT_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_WIDTH-1:0] in_rs1,
  input  logic [REG_WIDTH-1:0] in_rs2,
  input  logic [REG_WIDTH-1:0] in_rd,
  input  logic                 in_rd_wen,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_WIDTH-1:0] out_rs1,
  output logic [REG_WIDTH-1:0] out_rs2,
  output logic [REG_WIDTH-1:0] out_rd,
  output logic                 out_rd_wen,
  input  logic                 wb_valid,
  input  logic [REG_WIDTH-1:0] wb_rd,
  input  logic                 wb_rd_wen,
  input  logic                 flush,
  output logic                 stall,
  output logic                 sb_busy
);

  localparam int NUM_REGS = 2 ** REG_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_HOLD,
    ST_ISSUE
  } stage_state_e;

  stage_state_e         state;
  logic                 stage_valid;
  logic                 stage_valid_nxt;
  logic                 hazard;
  logic                 accept;
  logic                 issue;
  logic                 retire;
  logic                 issue_inc;
  logic [NUM_REGS-1:0]  reg_busy;
  logic [NUM_REGS-1:0]  reg_full;
  logic [NUM_REGS-1:0]  inc_vec;
  logic [NUM_REGS-1:0]  dec_vec;
  logic [CNT_WIDTH-1:0] cnt_q   [NUM_REGS];
  logic [CNT_WIDTH-1:0] cnt_nxt [NUM_REGS];

  assign retire    = wb_valid && wb_rd_wen && (wb_rd != '0);
  assign issue_inc = issue && out_rd_wen && (out_rd != '0);

  // Per-register hazard terms; entry 0 stays clear so x0 never blocks.
  always_comb begin
    reg_busy = '0;
    reg_full = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      reg_busy[r] = (cnt_q[r] != '0);
`ifdef YSYX_23060077_WB_BYPASS_EN
      if ((cnt_q[r] == CNT_WIDTH'(1)) && retire && (wb_rd == REG_WIDTH'(r)))
        reg_busy[r] = 1'b0;
`endif
      reg_full[r] = (cnt_q[r] == CNT_MAX);
    end
  end

  assign hazard = reg_busy[out_rs1] || reg_busy[out_rs2] ||
                  (out_rd_wen && reg_full[out_rd]);

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    state = ST_EMPTY;
    if (stage_valid) state = hazard ? ST_HOLD : ST_ISSUE;
  end

  assign out_valid = (state == ST_ISSUE) && !flush;
  assign stall     = (state == ST_HOLD) && !flush;
  assign in_ready  = !flush && (!stage_valid || (out_valid && out_ready));
  assign accept    = in_valid && in_ready;
  assign issue     = out_valid && out_ready;

  always_comb begin
    stage_valid_nxt = stage_valid;
    if (flush)       stage_valid_nxt = 1'b0;
    else if (accept) stage_valid_nxt = 1'b1;
    else if (issue)  stage_valid_nxt = 1'b0;
  end

  // A retire to an idle counter is dropped; issue and retire on one register cancel.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_vec[r] = issue_inc && (out_rd == REG_WIDTH'(r));
      dec_vec[r] = retire && (wb_rd == REG_WIDTH'(r)) && (cnt_q[r] != '0);
      cnt_nxt[r] = cnt_q[r];
      if (inc_vec[r] && !dec_vec[r])      cnt_nxt[r] = cnt_q[r] + CNT_WIDTH'(1);
      else if (dec_vec[r] && !inc_vec[r]) cnt_nxt[r] = cnt_q[r] - CNT_WIDTH'(1);
    end
  end

  always_comb begin
    sb_busy = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (cnt_q[r] != '0) sb_busy = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_rd_wen  <= 1'b0;
    end else begin
      stage_valid <= stage_valid_nxt;
      if (accept) begin
        out_rs1    <= in_rs1;
        out_rs2    <= in_rs2;
        out_rd     <= in_rd;
        out_rd_wen <= in_rd_wen;
      end
    end
  end

  // NOTE: the scoreboard is a small flop array, not RAM, and must reset so no phantom hazards survive reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_nxt[r];
    end
  end

endmodule

// File: tb/tb_ysyx_23060077_id_ctrl.sv
// Bench for ysyx_23060077_id_ctrl: directed scenarios then random traffic against an integer-count model.
module tb_ysyx_23060077_id_ctrl;

  localparam int RW   = 4;
  localparam int NREG = 16;
  localparam int MAXC = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [RW-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic          in_rd_wen = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] out_rs1, out_rs2, out_rd;
  logic          out_rd_wen;
  logic          wb_valid = 1'b0;
  logic [RW-1:0] wb_rd = '0;
  logic          wb_rd_wen = 1'b0;
  logic          flush = 1'b0;
  logic          stall;
  logic          sb_busy;

  ysyx_23060077_id_ctrl #(.REG_WIDTH(RW), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_rd_wen(out_rd_wen),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rd_wen(wb_rd_wen),
    .flush(flush), .stall(stall), .sb_busy(sb_busy)
  );

  always #5 clk = ~clk;

  // Reference model: in-flight write counts per register plus the held instruction.
  int          m_cnt [NREG];
  bit          m_valid;
  bit [RW-1:0] m_rs1, m_rs2, m_rd;
  bit          m_wen;
  bit          e_acc, e_iss;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    foreach (m_cnt[r]) m_cnt[r] = 0;
    m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_wen = 0;
  endfunction

  function automatic bit src_busy(input bit [RW-1:0] r);
    if (r == 0 || m_cnt[r] == 0) return 0;
`ifdef YSYX_23060077_WB_BYPASS_EN
    if (m_cnt[r] == 1 && wb_valid && wb_rd_wen && wb_rd == r) return 0;
`endif
    return 1;
  endfunction

  function automatic bit m_hazard();
    return src_busy(m_rs1) || src_busy(m_rs2) || (m_wen && m_rd != 0 && m_cnt[m_rd] == MAXC);
  endfunction

  task automatic eval();
    bit hz, ov, rdy, busy;
    #1;
    hz   = m_valid && m_hazard();
    ov   = m_valid && !hz && !flush;
    rdy  = !flush && (!m_valid || (ov && out_ready));
    busy = 0;
    foreach (m_cnt[r]) if (m_cnt[r] != 0) busy = 1;
    check("in_ready",   in_ready,   rdy);
    check("out_valid",  out_valid,  ov);
    check("stall",      stall,      hz && !flush);
    check("sb_busy",    sb_busy,    busy);
    check("out_rs1",    out_rs1,    m_rs1);
    check("out_rs2",    out_rs2,    m_rs2);
    check("out_rd",     out_rd,     m_rd);
    check("out_rd_wen", out_rd_wen, m_wen);
    e_acc = in_valid && rdy;
    e_iss = ov && out_ready;
  endtask

  task automatic adv();
    if (wb_valid && wb_rd_wen && wb_rd != 0 && m_cnt[wb_rd] > 0) m_cnt[wb_rd]--;
    if (e_iss && m_wen && m_rd != 0) m_cnt[m_rd]++;
    if (flush) m_valid = 0;
    else if (e_acc) begin
      m_valid = 1; m_rs1 = in_rs1; m_rs2 = in_rs2; m_rd = in_rd; m_wen = in_rd_wen;
    end else if (e_iss) m_valid = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    eval();
    adv();
  endtask

  task automatic put(input bit v, input bit [RW-1:0] rs1, input bit [RW-1:0] rs2,
                     input bit [RW-1:0] rd, input bit wen);
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_wen = wen;
  endtask

  task automatic wb(input bit v, input bit [RW-1:0] rd);
    wb_valid = v; wb_rd = rd; wb_rd_wen = v;
  endtask

  initial begin
    int q[$];
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sb_busy",   sb_busy,   0);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;

    // Back-to-back issue without hazards.
    put(1, 0, 0, 1, 1); step();
    put(1, 2, 0, 0, 0); eval();
    check("b2b_first_issue", out_valid, 1);
    check("b2b_ready", in_ready, 1);
    adv();
    put(0, 0, 0, 0, 0); eval();
    check("b2b_second_issue", out_valid, 1);
    check("b2b_cnt1_busy", sb_busy, 1);
    adv();
    wb(1, 1); step(); wb(0, 0);
    eval(); check("b2b_drained", sb_busy, 0); adv();

    // RAW on x3 released by a retire.
    put(1, 0, 0, 3, 1); step();
    put(1, 0, 3, 0, 0); step();
    put(0, 0, 0, 0, 0); eval();
    check("raw_stall", stall, 1);
    check("raw_hold_no_valid", out_valid, 0);
    adv();
    step();
    wb(1, 3); eval();
`ifdef YSYX_23060077_WB_BYPASS_EN
    check("raw_bypass_issue", out_valid, 1);
`else
    check("raw_retire_cycle_stall", stall, 1);
    check("raw_retire_cycle_no_valid", out_valid, 0);
`endif
    adv(); wb(0, 0);
`ifdef YSYX_23060077_WB_BYPASS_EN
    eval(); check("raw_bypass_empty", out_valid, 0); adv();
`else
    eval(); check("raw_next_issue", out_valid, 1); adv();
`endif

    // Saturation of x4 at three in-flight writes.
    put(1, 0, 0, 4, 1); repeat (4) step();
    put(0, 0, 0, 0, 0); eval(); check("sat_stall", stall, 1); adv();
    wb(1, 4); eval(); check("sat_retire_cycle_stall", stall, 1); adv(); wb(0, 0);
    eval(); check("sat_issue", out_valid, 1); adv();
    wb(1, 4); step(); step(); wb(0, 0);
    eval(); check("sat_one_left", sb_busy, 1); adv();
    wb(1, 4); step(); wb(0, 0);
    eval(); check("sat_drained", sb_busy, 0); adv();

    // x0 destination and retire underflow.
    put(1, 0, 0, 0, 1); step();
    put(0, 0, 0, 0, 0); step();
    wb(1, 0); step();
    wb(1, 7); step();
    wb(0, 0); eval(); check("x0_underflow_busy", sb_busy, 0); adv();

    // Flush of a stalled instruction with a concurrent retire.
    put(1, 0, 0, 5, 1); step(); step();
    put(1, 5, 0, 0, 0); step();
    put(0, 0, 0, 0, 0); eval(); check("fl_pre_stall", stall, 1); adv();
    put(1, 1, 1, 1, 1); flush = 1'b1; wb(1, 5); eval();
    check("fl_in_ready", in_ready, 0);
    check("fl_out_valid", out_valid, 0);
    adv();
    flush = 1'b0; put(0, 0, 0, 0, 0); wb(0, 0); eval();
    check("fl_empty_ready", in_ready, 1);
    check("fl_empty_stall", stall, 0);
    check("fl_cnt_kept", sb_busy, 1);
    adv();

    // Asynchronous reset mid-stall with cnt[5]=2.
    put(1, 0, 0, 5, 1); step();
    put(1, 5, 0, 0, 0); step();
    put(0, 0, 0, 0, 0); eval(); check("rst_pre_stall", stall, 1); adv();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_sb_busy", sb_busy, 0);
    check("arst_stall", stall, 0);
    check("arst_out_rd", out_rd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      put($urandom_range(0, 3) != 0, RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)),
          RW'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      q.delete();
      for (int r = 1; r < NREG; r++) if (m_cnt[r] > 0) q.push_back(r);
      if (q.size() > 0 && $urandom_range(0, 9) < 4) begin
        wb(1, RW'(q[$urandom_range(0, q.size() - 1)]));
      end else begin
        wb_valid = ($urandom_range(0, 7) == 0); wb_rd_wen = 1'b0; wb_rd = RW'($urandom_range(0, 15));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
